aes_serial_host: RTL and testbench

- Upstream/downstream partner of the serial AES core (Encrypt or Decrypt, same pin protocol).
- Accepts a parallel block and key through a valid/ready handshake, then shifts both serially into the core on miso.
- Waits for the core's finished pulse, shifts the 128-bit result back in from mosi, and presents it in parallel through a valid/ready handshake.

---
 rtl/aes_host_pkg.sv | 17 +
 rtl/aes_host_shifter.sv | 55 +++++
 rtl/aes_serial_host.sv | 141 ++++++++++++++
 tb/tb_aes_serial_host.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_host_pkg.sv
// Shared types and constants for the serial AES host: FSM state encoding,
// AES width constants and the sizing rule for the framing counter.
package aes_host_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, UNLOAD, DONE} host_state_e;

  localparam int AES_BLOCK_W  = 128;
  localparam int AES_KEY128_W = 128;
  localparam int AES_KEY192_W = 192;
  localparam int AES_KEY256_W = 256;

  // Counter spans the lead-in cycle plus every stream bit without wrapping.
  function automatic int cnt_width(input int stream_bits);
    return $clog2(stream_bits + 2);
  endfunction

endpackage

// File: rtl/aes_host_shifter.sv
// Serial datapath of the AES host: parallel-load PISO feeding miso (launched on
// the falling edge) and a SIPO collecting mosi LSB first into the result block.
module aes_host_shifter
#(
  parameter int BLOCK_W = 128,
  parameter int KEY_W   = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [BLOCK_W-1:0] data_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic               piso_en_i,
  input  logic               sipo_en_i,
  input  logic               mosi_i,
  output logic               miso_o,
  output logic [BLOCK_W-1:0] par_o
);

  localparam int STREAM_W = BLOCK_W + KEY_W;

  logic [STREAM_W-1:0] piso_q;
  logic [BLOCK_W-1:0]  sipo_q;
  logic                miso_q;

  // Data first, key after; bit 0 sits at the shift-out end.
  always_ff @(posedge clk) begin
    if (load_i) begin
      piso_q <= {key_i, data_i};
    end else if (piso_en_i) begin
      piso_q <= {1'b0, piso_q[STREAM_W-1:1]};
    end
  end

  // Launch on the falling edge so the core sees a full half-cycle of setup.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      miso_q <= 1'b0;
    end else begin
      miso_q <= piso_en_i & piso_q[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sipo_q <= '0;
    end else if (sipo_en_i) begin
      sipo_q <= {mosi_i, sipo_q[BLOCK_W-1:1]};
    end
  end

  assign miso_o = miso_q;
  assign par_o  = sipo_q;

endmodule

// File: rtl/aes_serial_host.sv
// Host side of the serial AES core protocol: handshake in, shift block+key out,
// wait for finished, shift result in, handshake out. Optional AES_HOST_TIMEOUT_EN.
module aes_serial_host
  import aes_host_pkg::*;
#(
  parameter int BLOCK_W        = AES_BLOCK_W,
  parameter int KEY_W          = AES_KEY128_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy,
  output logic               err,
  output logic               cs,
  output logic               miso,
  input  logic               mosi,
  input  logic               finished
);

  localparam int STREAM_W = BLOCK_W + KEY_W;
  localparam int CNT_W    = cnt_width(STREAM_W);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_LOAD   = LOAD;
  localparam logic [2:0] ST_WAIT   = WAIT;
  localparam logic [2:0] ST_UNLOAD = UNLOAD;
  localparam logic [2:0] ST_DONE   = DONE;

  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(STREAM_W);
  localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(BLOCK_W);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cs_q, cs_d;
  logic             accept, timeout;

  assign accept = (state_q == ST_IDLE) && in_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (cnt_q == LOAD_LAST) state_d = ST_WAIT;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ST_WAIT: begin
        if (finished) begin
          state_d = ST_UNLOAD;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_UNLOAD: begin
        if (cnt_q == UNLOAD_LAST) state_d = ST_DONE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // cs is registered from the next state so it never glitches on decode.
  assign cs_d = (state_d == ST_LOAD) || (state_d == ST_UNLOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
    end
  end

`ifdef AES_HOST_TIMEOUT_EN
  localparam int WT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WT_W-1:0] wcnt_q;
  logic            err_q;

  assign timeout = (state_q == ST_WAIT) && !finished &&
                   (wcnt_q == WT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= (state_q == ST_WAIT) ? wcnt_q + 1'b1 : '0;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  // Without the watchdog WAIT never expires; the parameter stays for interface parity.
  assign timeout = (TIMEOUT_CYCLES < 0);
  assign err     = 1'b0;
`endif

  aes_host_shifter #(
    .BLOCK_W (BLOCK_W),
    .KEY_W   (KEY_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .data_i    (in_data),
    .key_i     (in_key),
    .piso_en_i ((state_q == ST_LOAD) && (cnt_q != '0)),
    .sipo_en_i ((state_q == ST_UNLOAD) && (cnt_q != '0)),
    .mosi_i    (mosi),
    .miso_o    (miso),
    .par_o     (out_data)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign cs        = cs_q;

endmodule

// File: tb/tb_aes_serial_host.sv
// Bench for aes_serial_host: behavioural serial core model plus scenario tasks
// covering reset, framing, backpressure, mid-job reset, spurious finished, random jobs.
module tb_aes_serial_host;

  localparam int BW = 128;
  localparam int KW = 128;
  localparam int SW = BW + KW;
  localparam int TO = 16;

  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic [KW-1:0] in_key = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_data;
  logic          busy, err, cs, miso;
  logic          mosi = 1'b0;
  logic          finished = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_serial_host #(.BLOCK_W(BW), .KEY_W(KW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .err(err), .cs(cs), .miso(miso),
    .mosi(mosi), .finished(finished)
  );

  // Stand-in cipher: the real AES answer for the known vector, a keyed mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] blk, input logic [127:0] key);
    if (blk == KAT_PT && key == KAT_KEY) return KAT_CT;
    return blk ^ {key[63:0], key[127:64]} ^ 128'h5a5a_0ff0_c3c3_1234_8765_a5a5_f00f_3c3c;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Serial core model: phase 0 idle, 1 receiving, 2 computing, 3 finished issued, 4 sending.
  int           m_ph = 0;
  int           m_k = 0;
  int           m_lat = 0;
  bit           m_fin_en = 1'b1;
  logic         fin_req = 1'b0;
  logic         fin_tb = 1'b0;
  logic [SW-1:0] m_in = '0;
  logic [127:0] m_out = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_k = 0; fin_req = 1'b0;
    end else begin
      case (m_ph)
        0: if (cs) begin m_k = 1; m_ph = 1; end
        1: begin
          if (cs) begin
            m_in = {miso, m_in[SW-1:1]};
            m_k++;
          end else if (m_k == SW + 1) begin
            m_out = core_fn(m_in[127:0], m_in[SW-1:128]);
            m_lat = 3;
            m_ph  = 2;
          end else begin
            m_ph = 0;
          end
        end
        2: begin
          if (m_lat > 0) m_lat--;
          else if (m_fin_en) begin fin_req = 1'b1; m_ph = 3; end
        end
        3: begin
          fin_req = 1'b0;
          if (cs) m_ph = 4;
        end
        4: begin
          if (cs) m_out = m_out >> 1;
          else m_ph = 0;
        end
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    finished = fin_req | fin_tb;
    mosi     = (m_ph == 4) ? m_out[0] : 1'b0;
  end

  task automatic start_job(input logic [127:0] d, input logic [127:0] k);
    bit ok = 1'b0;
    @(negedge clk);
    in_data = d; in_key = k; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin @(posedge clk); #1; ok = 1'b1; break; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL start_job: in_ready=%b, required accept within 200 cycles", in_ready); end
  endtask

  task automatic wait_out();
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL wait_out: out_valid=%b, required 1 within 1000 cycles", out_valid); end
  endtask

  task automatic ack_out();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  // Records miso once per cycle while cs is high (first sample is the lead-in).
  task automatic sample_load(input int fin_at, output int run, output logic [SW:0] bits);
    bit fell = 1'b0;
    run = 0; bits = '0;
    for (int i = 0; i < 400 && !fell; i++) begin
      @(negedge clk); #2;
      fin_tb = (fin_at >= 0 && i == fin_at);
      if (cs) begin bits = {miso, bits[SW:1]}; run++; end
      else if (run > 0) fell = 1'b1;
    end
    fin_tb = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (cs !== 1'b0)        begin bad++; $display("FAIL reset_cs: got %b want 0", cs); end
    total++; if (miso !== 1'b0)      begin bad++; $display("FAIL reset_miso: got %b want 0", miso); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== '0)    begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_framing_kat();
    int run;
    logic [SW:0] bits;
    start_job(KAT_PT, KAT_KEY);
    sample_load(-1, run, bits);
    total++; if (run !== 257) begin bad++; $display("FAIL frame_len: cs high %0d cycles want 257", run); end
    total++; if (bits[0] !== 1'b0) begin bad++; $display("FAIL frame_leadin: miso %b want 0", bits[0]); end
    total++; if (bits[1] !== KAT_PT[0]) begin bad++; $display("FAIL frame_bit1: got %b want %b", bits[1], KAT_PT[0]); end
    total++; if (bits[129] !== KAT_KEY[0]) begin bad++; $display("FAIL frame_bit129: got %b want %b", bits[129], KAT_KEY[0]); end
    total++; if (bits[SW:1] !== {KAT_KEY, KAT_PT}) begin bad++; $display("FAIL frame_stream: got %h want %h", bits[SW:1], {KAT_KEY, KAT_PT}); end
    total++; if (cs !== 1'b0) begin bad++; $display("FAIL frame_cs_low: got %b want 0", cs); end
    wait_out();
    total++; if (out_data !== KAT_CT) begin bad++; $display("FAIL kat_result: got %h want %h", out_data, KAT_CT); end
    repeat (5) @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL kat_hold: out_valid %b want 1", out_valid); end
    ack_out();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL kat_release: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [127:0] da = rnd128(), ka = rnd128(), db = rnd128(), kb = rnd128();
    logic [127:0] held;
    start_job(da, ka);
    wait_out();
    held = out_data;
    total++; if (held !== core_fn(da, ka)) begin bad++; $display("FAIL bp_result_a: got %h want %h", held, core_fn(da, ka)); end
    in_data = db; in_key = kb; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      total++; if (out_data !== held) begin bad++; $display("FAIL bp_stable c%0d: got %h want %h", i, out_data, held); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c%0d: got %b want 0", i, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid c%0d: got %b want 1", i, out_valid); end
      total++; if (cs !== 1'b0) begin bad++; $display("FAIL bp_cs c%0d: got %b want 0", i, cs); end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || cs !== 1'b0)
      begin bad++; $display("FAIL bp_handshake: out_valid=%b in_ready=%b cs=%b want 0 1 0", out_valid, in_ready, cs); end
    @(posedge clk); #1; in_valid = 1'b0;
    total++; if (cs !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0)
      begin bad++; $display("FAIL bp_next_start: cs=%b busy=%b in_ready=%b want 1 1 0", cs, busy, in_ready); end
    wait_out();
    total++; if (out_data !== core_fn(db, kb)) begin bad++; $display("FAIL bp_result_b: got %h want %h", out_data, core_fn(db, kb)); end
    ack_out();
  endtask

  task automatic test_reset_mid_load();
    start_job(KAT_PT, KAT_KEY);
    repeat (100) @(posedge clk);
    @(negedge clk); #2; rst = 1'b1; #1;
    total++; if (cs !== 1'b0) begin bad++; $display("FAIL midrst_cs: got %b want 0", cs); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL midrst_miso: got %b want 0", miso); end
    @(negedge clk); rst = 1'b0;
    start_job(KAT_PT, KAT_KEY);
    wait_out();
    total++; if (out_data !== KAT_CT) begin bad++; $display("FAIL midrst_rerun: got %h want %h", out_data, KAT_CT); end
    ack_out();
  endtask

  task automatic test_spurious_finished();
    int run;
    logic [SW:0] bits;
    logic [127:0] d = rnd128(), k = rnd128();
    start_job(d, k);
    sample_load(50, run, bits);
    total++; if (run !== 257) begin bad++; $display("FAIL spur_len: cs high %0d cycles want 257", run); end
    total++; if (bits[SW:1] !== {k, d}) begin bad++; $display("FAIL spur_stream: got %h want %h", bits[SW:1], {k, d}); end
    wait_out();
    total++; if (out_data !== core_fn(d, k)) begin bad++; $display("FAIL spur_result: got %h want %h", out_data, core_fn(d, k)); end
    ack_out();
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++) begin
      logic [127:0] d = rnd128(), k = rnd128();
      start_job(d, k);
      wait_out();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      total++; if (out_data !== core_fn(d, k) || out_valid !== 1'b1)
        begin bad++; $display("FAIL rand_job%0d: got %h valid %b want %h valid 1", j, out_data, out_valid, core_fn(d, k)); end
      ack_out();
    end
  endtask

`ifdef AES_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int run, wcyc;
    logic [SW:0] bits;
    logic [127:0] prev = out_data;
    bit ov_seen = 1'b0;
    m_fin_en = 1'b0;
    start_job(rnd128(), rnd128());
    sample_load(-1, run, bits);
    wcyc = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      ov_seen |= out_valid;
      if (!busy) break;
      wcyc++;
    end
    repeat (5) begin @(negedge clk); ov_seen |= out_valid; end
    total++; if (wcyc !== TO) begin bad++; $display("FAIL to_cycles: WAIT lasted %0d want %0d", wcyc, TO); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err); end
    total++; if (in_ready !== 1'b1 || busy !== 1'b0 || cs !== 1'b0)
      begin bad++; $display("FAIL to_idle: in_ready=%b busy=%b cs=%b want 1 0 0", in_ready, busy, cs); end
    total++; if (ov_seen) begin bad++; $display("FAIL to_out_valid: rose=%b want 0", ov_seen); end
    total++; if (out_data !== prev) begin bad++; $display("FAIL to_out_data: got %h want %h", out_data, prev); end
    @(negedge clk); #2; rst = 1'b1; #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL to_err_clear: got %b want 0", err); end
    @(negedge clk); rst = 1'b0; m_fin_en = 1'b1;
  endtask
`else
  task automatic test_wait_hold();
    int run;
    logic [SW:0] bits;
    logic [127:0] d = rnd128(), k = rnd128();
    m_fin_en = 1'b0;
    start_job(d, k);
    sample_load(-1, run, bits);
    repeat (40) @(negedge clk);
    total++; if (busy !== 1'b1 || cs !== 1'b0 || out_valid !== 1'b0)
      begin bad++; $display("FAIL hold_wait: busy=%b cs=%b out_valid=%b want 1 0 0", busy, cs, out_valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL hold_err: got %b want 0", err); end
    m_fin_en = 1'b1;
    wait_out();
    total++; if (out_data !== core_fn(d, k)) begin bad++; $display("FAIL hold_result: got %h want %h", out_data, core_fn(d, k)); end
    ack_out();
  endtask
`endif

  initial begin
    test_reset();
    test_framing_kat();
    test_backpressure();
    test_reset_mid_load();
    test_spurious_finished();
    test_random();
`ifdef AES_HOST_TIMEOUT_EN
    test_timeout();
`else
    test_wait_hold();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
